// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID decode, EX resolution and hazard control signal bundle
interface hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic [4:0] id_rd_addr;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [1:0] id_wb_sel;
    logic       id_ecall;
    logic       ex_br_taken;

    logic       stall_if;
    logic       flush_if;
    logic       bubble_ex;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       halt;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_use_rs1, id_use_rs2, id_wb_sel, id_ecall, ex_br_taken,
        input  stall_if, flush_if, bubble_ex, fwd_a, fwd_b, halt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_use_rs1, id_use_rs2, id_wb_sel, id_ecall, ex_br_taken,
        output stall_if, flush_if, bubble_ex, fwd_a, fwd_b, halt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage RV32I stall/flush/forward control with ECALL drain-to-halt
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);

    localparam logic [1:0] WB_X   = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd2;

    localparam int             CNT_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0] ex_rd_q, ex_rd_d;
    logic       ex_wen_q, ex_wen_d;
    logic       ex_is_load_q, ex_is_load_d;
    logic [4:0] ex_rs1_q, ex_rs1_d;
    logic [4:0] ex_rs2_q, ex_rs2_d;
    logic       ex_use_rs1_q, ex_use_rs1_d;
    logic       ex_use_rs2_q, ex_use_rs2_d;
    logic [4:0] mem_rd_q, mem_rd_d;
    logic       mem_wen_q, mem_wen_d;
    logic [4:0] wb_rd_q, wb_rd_d;
    logic       wb_wen_q, wb_wen_d;

    logic       id_wen;
    logic       id_load;
    logic       load_use;
    logic       stall_if;
    logic       flush_if;
    logic       bubble_ex;
    logic       halt;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    always_comb begin
        id_wen   = bus.id_valid & (bus.id_wb_sel != WB_X) & (bus.id_rd_addr != 5'd0);
        id_load  = bus.id_valid & (bus.id_wb_sel == WB_MEM);
        load_use = bus.id_valid & ex_is_load_q & (ex_rd_q != 5'd0) &
                   ((bus.id_use_rs1 & (bus.id_rs1_addr == ex_rd_q)) |
                    (bus.id_use_rs2 & (bus.id_rs2_addr == ex_rd_q)));
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB
    always_comb begin
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (ex_use_rs1_q && mem_wen_q && (mem_rd_q == ex_rs1_q)) begin
            fwd_a_raw = 2'b01;
        end else if (ex_use_rs1_q && wb_wen_q && (wb_rd_q == ex_rs1_q)) begin
            fwd_a_raw = 2'b10;
        end
        if (ex_use_rs2_q && mem_wen_q && (mem_rd_q == ex_rs2_q)) begin
            fwd_b_raw = 2'b01;
        end else if (ex_use_rs2_q && wb_wen_q && (wb_rd_q == ex_rs2_q)) begin
            fwd_b_raw = 2'b10;
        end
    end

    // A taken branch squashes the instruction in ID, including an ECALL
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_if  = 1'b0;
        flush_if  = 1'b0;
        bubble_ex = 1'b0;
        halt      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.ex_br_taken) begin
                    flush_if  = 1'b1;
                    bubble_ex = 1'b1;
                end else if (load_use) begin
                    stall_if  = 1'b1;
                    bubble_ex = 1'b1;
                end else if (bus.id_ecall && bus.id_valid) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_DRAIN: begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_HALTED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HALTED: begin
                halt     = 1'b1;
                stall_if = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ex_rd_d      = ex_rd_q;
        ex_wen_d     = ex_wen_q;
        ex_is_load_d = ex_is_load_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_use_rs1_d = ex_use_rs1_q;
        ex_use_rs2_d = ex_use_rs2_q;
        mem_rd_d     = mem_rd_q;
        mem_wen_d    = mem_wen_q;
        wb_rd_d      = wb_rd_q;
        wb_wen_d     = wb_wen_q;
        if (!halt) begin
            if (bubble_ex) begin
                ex_rd_d      = 5'd0;
                ex_wen_d     = 1'b0;
                ex_is_load_d = 1'b0;
                ex_rs1_d     = 5'd0;
                ex_rs2_d     = 5'd0;
                ex_use_rs1_d = 1'b0;
                ex_use_rs2_d = 1'b0;
            end else begin
                ex_rd_d      = bus.id_rd_addr;
                ex_wen_d     = id_wen;
                ex_is_load_d = id_load;
                ex_rs1_d     = bus.id_rs1_addr;
                ex_rs2_d     = bus.id_rs2_addr;
                ex_use_rs1_d = bus.id_use_rs1;
                ex_use_rs2_d = bus.id_use_rs2;
            end
            mem_rd_d  = ex_rd_q;
            mem_wen_d = ex_wen_q;
            wb_rd_d   = mem_rd_q;
            wb_wen_d  = mem_wen_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            ex_rd_q      <= 5'd0;
            ex_wen_q     <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_rs1_q     <= 5'd0;
            ex_rs2_q     <= 5'd0;
            ex_use_rs1_q <= 1'b0;
            ex_use_rs2_q <= 1'b0;
            mem_rd_q     <= 5'd0;
            mem_wen_q    <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_wen_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ex_rd_q      <= ex_rd_d;
            ex_wen_q     <= ex_wen_d;
            ex_is_load_q <= ex_is_load_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_use_rs1_q <= ex_use_rs1_d;
            ex_use_rs2_q <= ex_use_rs2_d;
            mem_rd_q     <= mem_rd_d;
            mem_wen_q    <= mem_wen_d;
            wb_rd_q      <= wb_rd_d;
            wb_wen_q     <= wb_wen_d;
        end
    end

    assign bus.stall_if  = stall_if;
    assign bus.flush_if  = flush_if;
    assign bus.bubble_ex = bubble_ex;
    assign bus.halt      = halt;
    assign bus.fwd_a     = halt ? 2'b00 : fwd_a_raw;
    assign bus.fwd_b     = halt ? 2'b00 : fwd_b_raw;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam logic [1:0] WB_X   = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    hazard_ctrl_if bus ();

    hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ctl bits are {stall_if, flush_if, bubble_ex, halt}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {4'b0, bus.stall_if, bus.flush_if, bus.bubble_ex, bus.halt}, {4'b0, exp});
    endtask

    task automatic chk_fwd(input string tag, input logic [3:0] exp);
        chk(tag, {4'b0, bus.fwd_a, bus.fwd_b}, {4'b0, exp});
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic [1:0] wb, input logic ec, input logic br);
        bus.id_valid    = v;
        bus.id_rs1_addr = rs1;
        bus.id_rs2_addr = rs2;
        bus.id_rd_addr  = rd;
        bus.id_use_rs1  = u1;
        bus.id_use_rs2  = u2;
        bus.id_wb_sel   = wb;
        bus.id_ecall    = ec;
        bus.ex_br_taken = br;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, WB_X, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        @(negedge clk); #1;
        chk_ctl("reset_ctl", 4'b0000);
        chk_fwd("reset_fwd", 4'b0000);
        rst_n = 1'b1;

        // load-use: LW x5 then ADD x6,x5,x1
        @(negedge clk); drive(1, 5'd2, 5'd0, 5'd5, 1, 0, WB_MEM, 0, 0); #1;
        chk_ctl("lw_issue", 4'b0000);
        @(negedge clk); drive(1, 5'd5, 5'd1, 5'd6, 1, 1, WB_ALU, 0, 0); #1;
        chk_ctl("lu_stall", 4'b1010);
        @(negedge clk); #1;
        chk_ctl("lu_release", 4'b0000);
        chk_fwd("lu_bubble_fwd", 4'b0000);
        @(negedge clk); nop(); #1;
        chk_ctl("lu_add_ex", 4'b0000);
        chk_fwd("lu_fwd_wb", 4'b1000);

        // EX/MEM beats MEM/WB on x3
        @(negedge clk); drive(1, 5'd0, 5'd0, 5'd3, 1, 0, WB_ALU, 0, 0); #1;
        @(negedge clk); drive(1, 5'd0, 5'd0, 5'd3, 1, 0, WB_ALU, 0, 0); #1;
        @(negedge clk); drive(1, 5'd3, 5'd3, 5'd4, 1, 1, WB_ALU, 0, 0); #1;
        chk_ctl("fwd_no_stall", 4'b0000);
        @(negedge clk); nop(); #1;
        chk_fwd("fwd_mem_prio", 4'b0101);

        // same with rd=x0: never forwards
        @(negedge clk); drive(1, 5'd0, 5'd0, 5'd0, 1, 0, WB_ALU, 0, 0); #1;
        @(negedge clk); drive(1, 5'd0, 5'd0, 5'd0, 1, 0, WB_ALU, 0, 0); #1;
        @(negedge clk); drive(1, 5'd0, 5'd0, 5'd4, 1, 1, WB_ALU, 0, 0); #1;
        @(negedge clk); nop(); #1;
        chk_fwd("fwd_x0", 4'b0000);

        // load-use and taken branch together: branch wins
        @(negedge clk); drive(1, 5'd1, 5'd0, 5'd7, 1, 0, WB_MEM, 0, 0); #1;
        @(negedge clk); drive(1, 5'd7, 5'd7, 5'd8, 1, 1, WB_ALU, 0, 1); #1;
        chk_ctl("br_over_lu", 4'b0110);
        @(negedge clk); nop(); #1;
        chk_ctl("br_no_residual", 4'b0000);
        chk_fwd("br_bubble_fwd", 4'b0000);

        // ECALL squashed by a taken branch
        @(negedge clk); drive(1, 5'd0, 5'd0, 5'd0, 0, 0, WB_X, 1, 1); #1;
        chk_ctl("ecall_br", 4'b0110);
        @(negedge clk); nop(); #1;
        chk_ctl("ecall_br_run1", 4'b0000);
        @(negedge clk); #1;
        chk_ctl("ecall_br_run2", 4'b0000);

        // ECALL drain to halt
        @(negedge clk); drive(1, 5'd0, 5'd0, 5'd0, 0, 0, WB_X, 1, 0); #1;
        chk_ctl("ecall_id", 4'b0000);
        @(negedge clk); drive(1, 5'd1, 5'd2, 5'd12, 1, 1, WB_ALU, 0, 1); #1;
        chk_ctl("drain1_br_ignored", 4'b1010);
        @(negedge clk); drive(1, 5'd1, 5'd2, 5'd12, 1, 1, WB_ALU, 0, 0); #1;
        chk_ctl("drain2", 4'b1010);
        @(negedge clk); #1;
        chk_ctl("drain3", 4'b1010);
        @(negedge clk); #1;
        chk_ctl("halt_rise", 4'b1001);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            chk_ctl("halt_hold", 4'b1001);
            chk_fwd("halt_fwd", 4'b0000);
            chk("halt_ex_rd", 8'(dut.ex_rd_q), 8'd0);
            chk("halt_ex_wen", 8'(dut.ex_wen_q), 8'd0);
        end

        @(negedge clk); rst_n = 1'b0; #1;
        chk_ctl("halt_reset", 4'b0000);

        // reset asynchronously during the 2nd DRAIN cycle
        @(negedge clk); rst_n = 1'b1; drive(1, 5'd0, 5'd0, 5'd0, 0, 0, WB_X, 1, 0); #1;
        chk_ctl("ecall2_id", 4'b0000);
        @(negedge clk); nop(); #1;
        chk_ctl("ecall2_drain1", 4'b1010);
        @(negedge clk); #1;
        chk_ctl("ecall2_drain2", 4'b1010);
        #2 rst_n = 1'b0;
        #1;
        chk_ctl("async_reset_ctl", 4'b0000);
        chk_fwd("async_reset_fwd", 4'b0000);

        @(negedge clk); rst_n = 1'b1; drive(1, 5'd0, 5'd0, 5'd3, 1, 0, WB_ALU, 0, 0); #1;
        chk_ctl("post_rst_addi", 4'b0000);
        @(negedge clk); drive(1, 5'd3, 5'd3, 5'd4, 1, 1, WB_ALU, 0, 0); #1;
        chk_ctl("post_rst_add", 4'b0000);
        @(negedge clk); nop(); #1;
        chk_ctl("post_rst_run", 4'b0000);
        chk_fwd("post_rst_fwd", 4'b0101);
        @(negedge clk); #1;
        chk_ctl("post_rst_idle", 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
